uart_rx_loader: RTL and testbench

- Command controller sequencing the UART receiver's byte stream into the MIPS core.
- Decodes command bytes, assembles program bytes into 32-bit words and writes them into instruction memory.
- Starts, steps and stops the CPU.
- Sits between the UART receiver (done strobe, byte, parity) and the instruction-memory write port / CPU run control.

---
 rtl/uart_rx_loader.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// UART command loader: decodes command bytes, packs program words into imem, drives CPU run/step.
// Define UART_RX_LOADER_PARITY_CHECK_EN to reject received bytes whose even parity does not match.
module uart_rx_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [7:0]            i_rx_byte,
  input  logic                  i_rx_parity,
  input  logic                  i_cpu_halt,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  output logic                  o_run,
  output logic                  o_step,
  output logic                  o_busy,
  output logic                  o_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_STEP  = 8'h03;
  localparam logic [7:0] CMD_CLEAR = 8'h04;
  localparam logic [7:0] CMD_STOP  = 8'h05;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [31:0]           word_q, word_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [31:0]           mdata_q, mdata_d;
  logic                  run_q, run_d;
  logic                  step_q, step_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic par_ok;
  logic rx_ok;
  logic rx_bad;

`ifdef UART_RX_LOADER_PARITY_CHECK_EN
  assign par_ok = ((^i_rx_byte) == i_rx_parity);
`else
  assign par_ok = 1'b1;
`endif

  assign rx_ok  = i_rx_done & par_ok;
  assign rx_bad = i_rx_done & ~par_ok;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    word_d  = word_q;
    wr_en_d = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    run_d   = run_q;
    step_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (rx_bad) begin
          err_d = 1'b1;
        end else if (rx_ok) begin
          case (i_rx_byte)
            CMD_LOAD: begin
              state_d = S_LOAD;
              addr_d  = '0;
              idx_d   = '0;
              tmo_d   = '0;
            end
            CMD_RUN: begin
              run_d   = 1'b1;
              state_d = S_RUN;
            end
            CMD_STEP:  step_d = 1'b1;
            CMD_CLEAR: err_d  = 1'b0;
            default:   err_d  = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (rx_bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rx_ok) begin
          // An arriving byte beats a same-cycle timeout expiry.
          word_d = {i_rx_byte, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          tmo_d  = '0;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
            wr_en_d = 1'b1;
            maddr_d = addr_q;
            mdata_d = {i_rx_byte, word_q[31:8]};
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (i_rx_done) err_d = 1'b1;
        if (mdata_q == END_WORD) begin
          state_d = S_IDLE;
        end else if (addr_q == ADDR_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          idx_d   = '0;
          tmo_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (rx_bad) err_d = 1'b1;
        if (i_cpu_halt || (rx_ok && i_rx_byte == CMD_STOP)) begin
          run_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        run_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      word_q  <= '0;
      wr_en_q <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      word_q  <= word_d;
      wr_en_q <= wr_en_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      run_q   <= run_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_wr_en = wr_en_q;
  assign o_mem_addr  = maddr_q;
  assign o_mem_data  = mdata_q;
  assign o_run       = run_q;
  assign o_step      = step_q;
  assign o_busy      = busy_q;
  assign o_error     = err_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Scoreboard bench for uart_rx_loader: expected writes queued by stimulus, popped by a monitor.
// Small ADDR_WIDTH and TIMEOUT_CYCLES keep overflow and timeout cases short.
module tb_uart_rx_loader;

  localparam int AW = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_par = 1'b0;
  logic          halt = 1'b0;
  logic          wr_en;
  logic [AW-1:0] maddr;
  logic [31:0]   mdata;
  logic          run;
  logic          step;
  logic          busy;
  logic          err;

  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  wr_t exp_q[$];

  uart_rx_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(100),
    .END_WORD      (32'hFFFF_FFFF)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_rx_done  (rx_done),
    .i_rx_byte  (rx_byte),
    .i_rx_parity(rx_par),
    .i_cpu_halt (halt),
    .o_mem_wr_en(wr_en),
    .o_mem_addr (maddr),
    .o_mem_data (mdata),
    .o_run      (run),
    .o_step     (step),
    .o_busy     (busy),
    .o_error    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_p(input logic [7:0] b, input logic p);
    @(negedge clk);
    rx_byte = b;
    rx_par  = p;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_p(b, ^b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %h data %h", maddr, mdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (maddr !== e.a || mdata !== e.d) begin
          errors++;
          $display("FAIL write: got %h/%h expected %h/%h",
                   maddr, mdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    idle(3);
    chk("rst_busy", busy, 0);
    chk("rst_run", run, 0);
    chk("rst_err", err, 0);
    chk("rst_wr", wr_en, 0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_busy", busy, 0);
    chk("idle_step", step, 0);

    // Load two words, the second being the end marker
    send(8'h01);
    chk("load_busy", busy, 1);
    exp_q.push_back('{a: 2'd0, d: 32'h1234_5678});
    send_word(32'h1234_5678);
    exp_q.push_back('{a: 2'd1, d: 32'hFFFF_FFFF});
    send_word(32'hFFFF_FFFF);
    idle(2);
    chk("load_done_busy", busy, 0);
    chk("load_err", err, 0);
    chk("load_wr_cnt", wr_cnt, 2);

    // Timeout after 100 silent cycles
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    idle(99);
    chk("tmo_err_early", err, 0);
    chk("tmo_busy_early", busy, 1);
    idle(1);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    send(8'h04);
    chk("clear_err", err, 0);
    chk("tmo_wr_cnt", wr_cnt, 2);

    // Run, ignore other byte, stop, run again, halt
    send(8'h02);
    chk("run_on", run, 1);
    chk("run_busy", busy, 1);
    send(8'h33);
    chk("run_ignore", run, 1);
    chk("run_ignore_err", err, 0);
    send(8'h05);
    chk("run_stop", run, 0);
    chk("run_stop_busy", busy, 0);
    send(8'h02);
    chk("run_on2", run, 1);
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_run", run, 0);
    chk("halt_busy", busy, 0);
    chk("halt_err", err, 0);

    // Step pulse, then bad command
    send(8'h03);
    chk("step_hi", step, 1);
    idle(1);
    chk("step_lo", step, 0);
    send(8'h7E);
    chk("bad_err", err, 1);
    chk("bad_step", step, 0);
    send(8'h04);
    chk("bad_clear", err, 0);

    // Address overflow: max-address word written, then error
    send(8'h01);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{a: AW'(i), d: 32'hA000_0000 + i});
      send_word(32'hA000_0000 + i);
    end
    idle(2);
    chk("ovf_err", err, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_wr_cnt", wr_cnt, 6);
    send(8'h04);

    // Reset in the middle of a load aborts it
    send(8'h01);
    send(8'h78);
    send(8'h56);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_run", run, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("mid_rst_wr_cnt", wr_cnt, 6);

`ifdef UART_RX_LOADER_PARITY_CHECK_EN
    send(8'h01);
    send_p(8'h03, 1'b1);
    chk("par_err", err, 1);
    chk("par_busy", busy, 0);
    send(8'h78);
    chk("par_cmd_err", err, 1);
    chk("par_cmd_busy", busy, 0);
    idle(2);
    chk("par_wr_cnt", wr_cnt, 6);
`endif

    idle(2);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
